seg_encoder: RTL
================

SEG_ENCODER -- requirements
Module: seg_encoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..15: consecutive cycles a pattern must hold before decode.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port seg_in  input  7  segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-005 SHALL have port seg_vld  input  1  strobe; seg_in presented for capture.
REQ-006 SHALL have port out_rdy  input  1  consumer ready for result.
REQ-007 SHALL have port val_out  output  4  decoded hex value.
REQ-008 SHALL have port err  output  1  captured pattern matched no hex glyph.
REQ-009 SHALL have port out_vld  output  1  val_out/err valid.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port err_cnt  output  8  count of error results, saturating.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, DECODE, OUT; busy=0 only in IDLE.
REQ-013 SHALL, in IDLE with seg_vld=1, latch seg_in into capture register and go to SETTLE (see REQ-025) or DECODE; seg_vld SHALL be ignored outside IDLE.
REQ-014 SHALL, in SETTLE, compare seg_in to capture each cycle: equal -> stable counter +1; differ -> capture<=seg_in, counter<=0, stay in SETTLE.
REQ-015 SHALL leave SETTLE for DECODE at the edge ending the STABLE_CYCLES-th consecutive equal cycle.
REQ-016 SHALL, in DECODE (exactly one cycle), map capture to value: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F.
REQ-017 SHALL, for any other pattern, including 00, register err=1 and val_out=0; matched pattern registers err=0.
REQ-018 SHALL increment err_cnt by 1 per error result, holding at 255 (no wrap).
REQ-019 SHALL, in OUT, drive out_vld=1 with val_out/err stable until out_rdy=1 is sampled.
REQ-020 SHALL complete handshake in any cycle with out_vld=1 and out_rdy=1, including the first OUT cycle; next state IDLE, out_vld=0.
REQ-021 SHALL ignore a seg_vld asserted in the handshake cycle; it is accepted only in a later IDLE cycle.
REQ-022 SHALL hold val_out and err at their last values after handshake until the next DECODE.
REQ-023 SHALL ignore out_rdy when out_vld=0.

Reset
REQ-024 SHALL, on rst=1, immediately and asynchronously force state IDLE, val_out=0, err=0, out_vld=0, busy=0, err_cnt=0, capture=0, stable counter=0, including mid-SETTLE or mid-OUT; no result survives reset.

Configuration
REQ-025 SHALL support macro SEG_ENC_STABLE_EN: defined -> SETTLE filter per REQ-014/015, out_vld first high STABLE_CYCLES+2 cycles after capture edge; undefined -> IDLE goes directly to DECODE, no SETTLE state or counter logic, out_vld first high 2 cycles after capture edge.

Verification
REQ-026 SHALL check: macro undefined, seg_in=5B with seg_vld pulse, out_rdy=1 -> out_vld high 2 cycles later for 1 cycle, val_out=2, err=0.
REQ-027 SHALL check: macro defined, STABLE_CYCLES=4, seg_in=7C held -> out_vld at capture+6, val_out=B; seg_in changed to 39 at capture+2 -> out_vld delayed to capture+8, val_out=C.
REQ-028 SHALL check: seg_in=00, then 7E -> err=1, val_out=0 each; err_cnt=2; 300 error results -> err_cnt=255.
REQ-029 SHALL check: out_rdy=0 for 10 cycles in OUT -> out_vld, val_out stable; seg_vld pulses with other pattern ignored; out_rdy=1 -> IDLE next cycle.
REQ-030 SHALL check: rst pulsed between clock edges while in SETTLE and in OUT -> all outputs 0 before next clk edge; next strobe decodes normally.

Source files
------------

// File: rtl/seg_encoder.sv
// ---------------------------------------------------------------------------
// seg_encoder
//
// Decodes a captured active-high seven-segment pattern {g,f,e,d,c,b,a} into
// its hex digit. The result is held behind a valid/ready handshake. Patterns
// that match no hex glyph produce err=1 with val_out=0. Error results are
// counted in a saturating 8-bit counter.
//
// Build option:
//   SEG_ENC_STABLE_EN - when defined, a captured pattern must stay unchanged
//                       on seg_in for STABLE_CYCLES consecutive cycles (the
//                       SETTLE state) before it is decoded. When undefined,
//                       a capture goes straight to DECODE.
//
// Ports:
//   clk      in   1  sole clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   seg_in   in   7  segment pattern {g,f,e,d,c,b,a}
//   seg_vld  in   1  capture strobe, honoured only in IDLE
//   out_rdy  in   1  consumer ready, honoured only while out_vld=1
//   val_out  out  4  decoded hex value (held after handshake)
//   err      out  1  captured pattern matched no glyph (held after handshake)
//   out_vld  out  1  val_out/err valid
//   busy     out  1  high in every state except IDLE
//   err_cnt  out  8  saturating count of error results
// ---------------------------------------------------------------------------
module seg_encoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   input  logic       seg_vld,
   input  logic       out_rdy,
   output logic [3:0] val_out,
   output logic       err,
   output logic       out_vld,
   output logic       busy,
   output logic [7:0] err_cnt
);

   if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable_cycles
      $error("seg_encoder: STABLE_CYCLES must be in 1..15");
   end

`ifdef SEG_ENC_STABLE_EN
   typedef enum logic [1:0] {IDLE, SETTLE, DECODE, OUT} state_t;
   // Value the counter holds during the last equal cycle of the filter.
   localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
   logic [3:0] stable_cnt_q, stable_cnt_d;
`else
   typedef enum logic [1:0] {IDLE, DECODE, OUT} state_t;
`endif

   state_t     state_q, state_d;
   logic [6:0] capture_q, capture_d;
   logic [3:0] val_q, val_d;
   logic       err_q, err_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   logic [3:0] dec_val;
   logic       dec_hit;

   // Glyph lookup on the captured pattern.
   always_comb begin
      dec_val = 4'h0;
      dec_hit = 1'b1;
      case (capture_q)
         7'h3F: dec_val = 4'h0;
         7'h06: dec_val = 4'h1;
         7'h5B: dec_val = 4'h2;
         7'h4F: dec_val = 4'h3;
         7'h66: dec_val = 4'h4;
         7'h6D: dec_val = 4'h5;
         7'h7D: dec_val = 4'h6;
         7'h07: dec_val = 4'h7;
         7'h7F: dec_val = 4'h8;
         7'h6F: dec_val = 4'h9;
         7'h77: dec_val = 4'hA;
         7'h7C: dec_val = 4'hB;
         7'h39: dec_val = 4'hC;
         7'h5E: dec_val = 4'hD;
         7'h79: dec_val = 4'hE;
         7'h71: dec_val = 4'hF;
         default: dec_hit = 1'b0;
      endcase
   end

   // Next-state and datapath updates.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_d      = state_q;
      capture_d    = capture_q;
      val_d        = val_q;
      err_d        = err_q;
      err_cnt_d    = err_cnt_q;
`ifdef SEG_ENC_STABLE_EN
      stable_cnt_d = stable_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (seg_vld) begin
               capture_d = seg_in;
`ifdef SEG_ENC_STABLE_EN
               stable_cnt_d = 4'd0;
               state_d      = SETTLE;
`else
               state_d      = DECODE;
`endif
            end
         end
`ifdef SEG_ENC_STABLE_EN
         SETTLE: begin
            if (seg_in != capture_q) begin
               // Pattern moved: restart the filter on the new pattern.
               capture_d    = seg_in;
               stable_cnt_d = 4'd0;
            end else if (stable_cnt_q == STABLE_LAST) begin
               stable_cnt_d = 4'd0;
               state_d      = DECODE;
            end else begin
               stable_cnt_d = stable_cnt_q + 4'd1;
            end
         end
`endif
         DECODE: begin
            val_d = dec_hit ? dec_val : 4'h0;
            err_d = ~dec_hit;
            if (!dec_hit && err_cnt_q != 8'hFF) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d = OUT;
         end
         OUT: begin
            if (out_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   // NOTE: the capture register and stable counter are reset too, so a
   // reset in mid-transaction leaves no stale pattern behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         capture_q    <= 7'h00;
         val_q        <= 4'h0;
         err_q        <= 1'b0;
         err_cnt_q    <= 8'h00;
`ifdef SEG_ENC_STABLE_EN
         stable_cnt_q <= 4'd0;
`endif
      end else begin
         state_q      <= state_d;
         capture_q    <= capture_d;
         val_q        <= val_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
`ifdef SEG_ENC_STABLE_EN
         stable_cnt_q <= stable_cnt_d;
`endif
      end
   end

   assign val_out = val_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign out_vld = (state_q == OUT);
   assign busy    = (state_q != IDLE);

endmodule
